piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a
//   valid/ready load handshake and shifts it out one bit per clk on ser_out,
//   with ser_valid and ser_last as framing. It is the transmit end of the
//   serial shift-register link: by default it sends LSB first, so a
//   downstream WIDTH-bit serial-in/parallel-out register, which shifts in at
//   the MSB end, holds the word in order after WIDTH clocks.
// PARAMETERS
//   WIDTH      4  word length in bits; legal range is >= 1
//   LSB_FIRST  1  1 = send bit 0 first; 0 = send bit WIDTH-1 first
//   IDLE_LEVEL 0  value driven on ser_out while no frame is active
// PORTS
//   clk        in   1      clock; all state changes on the rising edge
//   rst        in   1      reset; synchronous, active-high
//   load_valid in   1      load_data is valid
//   load_ready out  1      block can accept a word this cycle
//   load_data  in   WIDTH  word to serialize
//   ser_out    out  1      serial data bit
//   ser_valid  out  1      ser_out carries a frame bit this cycle
//   ser_last   out  1      ser_out carries the final bit of the frame
//   busy       out  1      frame in progress (equal to ser_valid)
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): FSM goes to IDLE, shift reg and bit
//     counter clear, ser_out=IDLE_LEVEL, ser_valid=ser_last=busy=0.
//     load_ready=0 while rst=1.
//   - Reset mid-frame aborts the frame immediately. No further frame bits
//     are sent. A load_valid coinciding with rst is dropped.
//   - FSM states:
//       IDLE:  load_ready=1. Accept when load_valid & load_ready, then go
//              to SHIFT.
//       SHIFT: WIDTH cycles, one bit per cycle.
//   - Handshake: transfer occurs on any edge where load_valid & load_ready.
//     load_data is sampled only on that edge. The source must hold
//     load_data stable while load_valid=1 and load_ready=0.
//   - Latency: when a word is accepted at edge N, its first bit is on
//     ser_out with ser_valid=1 in the cycle after edge N. Its last bit is
//     in the cycle after edge N+WIDTH-1. All outputs are registered.
//   - Bit order:
//       LSB_FIRST=1: bit0, bit1, ..., bit[WIDTH-1].
//       LSB_FIRST=0: the reverse order.
//   - ser_last=1 only during the final bit cycle of a frame. A bit counter
//     of $clog2(WIDTH)+1 bits counts 0..WIDTH-1 and has no wrap beyond
//     WIDTH-1.
//   - In SHIFT, load_ready=1 only in the ser_last cycle. A word accepted
//     there starts its first bit in the very next cycle, giving continuous
//     back-to-back frames with no gap and ser_valid held high.
//   - If no word is accepted in the ser_last cycle, return to IDLE:
//     ser_out=IDLE_LEVEL, ser_valid=0.
//   - load_valid while busy and not in the ser_last cycle: no transfer and
//     no effect on the frame in flight.
//   - WIDTH=1: every frame is one cycle, with ser_valid=ser_last=1 and
//     load_ready held at 1.
// STRUCTURE
//   - Shared package: FSM state enum {IDLE, SHIFT} and the counter-width
//     function/localparam CNT_W = $clog2(WIDTH)+1.
//   - One sub-module, piso_shift_reg: WIDTH-bit loadable shift register
//     with sync reset, load, and shift direction set by LSB_FIRST. The FSM,
//     counter and handshake stay in the top module.
// TESTING (WIDTH=4, LSB_FIRST=1, IDLE_LEVEL=0 unless stated)
//   1. Reset, then load 4'b1011 -> ser_out 1,1,0,1 over 4 cycles;
//      ser_last only on the 4th; load_ready=0 for cycles 1-3.
//   2. Load 4'hA, then offer 4'h5 in the ser_last cycle -> ser_out
//      0,1,0,1,1,0,1,0 with ser_valid continuously 1 for 8 cycles.
//   3. Load 4'hF, pulse load_valid with 4'h0 in cycle 2 -> word ignored;
//      ser_out stays 1,1,1,1, then idle (ser_valid=0, ser_out=0).
//   4. Load 4'hC, assert rst in bit cycle 2 -> next cycle ser_valid=0,
//      ser_out=0, load_ready=1 after rst drops; a new load of 4'h3
//      serializes as 1,1,0,0.
//   5. LSB_FIRST=0, load 4'b1000 -> ser_out 1,0,0,0; WIDTH=1 build: loads
//      1,0,1 back-to-back -> ser_out 1,0,1 with ser_last=1 every cycle.
//   6. Loopback into a 4-bit serial-in/parallel-out register clocked on
//      clk: random words back-to-back; the receiver word equals the sent
//      word 4 cycles after the first bit.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
// The bit counter width depends on WIDTH, so it is provided as a function.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter spans 0..width-1 and keeps one spare bit so WIDTH=1 still gets a 1-bit counter.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/piso_serializer_shift_reg.sv
// Loadable WIDTH-bit shift register whose head bit drives the serial line.
// Vacated positions fill with the idle level, so the head returns to idle when a frame drains.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             fill,
    input  logic [WIDTH-1:0] data,
    output logic             head
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_single
            assign shifted = fill;
        end else if (LSB_FIRST) begin : g_lsb
            assign shifted = {fill, q[WIDTH-1:1]};
        end else begin : g_msb
            assign shifted = {q[WIDTH-2:0], fill};
        end
    endgenerate

    // Reset fills with the idle level, which is all-zero for the default IDLE_LEVEL.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {WIDTH{fill}};
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            q <= shifted;
        end
    end

    assign head = LSB_FIRST ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per clk on ser_out.
// A word offered in the final bit cycle of a frame follows it with no gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             at_last;
    logic             accept;
    logic             shift_en;

    // Handshake: a word transfers on any edge where load_valid and load_ready are both high;
    // load_ready is high in IDLE and in the final bit cycle of a frame, never while rst is high.
    assign at_last    = (state == SHIFT) && (cnt == LAST_CNT);
    assign load_ready = !rst && ((state == IDLE) || at_last);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (accept) begin
                    cnt_next = '0;
                end else if (at_last) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A load takes priority over the shift, so a back-to-back word replaces the drained frame.
    piso_shift_reg #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_shift_reg (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(shift_en),
        .fill (IDLE_LEVEL),
        .data (load_data),
        .head (ser_out)
    );

    assign ser_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign ser_last  = at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed vector table, hand-written corner sequences for
// MSB-first and WIDTH=1 builds, and random back-to-back traffic against a bit-queue model.
module tb_piso_serializer;

    logic clk;
    logic rst;

    logic       lv, ready, sout, svalid, slast, sbusy;
    logic [3:0] ld;
    logic       lv_m, ready_m, sout_m, svalid_m, slast_m, sbusy_m;
    logic [3:0] ld_m;
    logic       lv_1, ready_1, sout_1, svalid_1, slast_1, sbusy_1;
    logic [0:0] ld_1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:0] exp_q[$];
    logic [3:0] word_q[$];
    logic       prev_last;
    logic [3:0] sipo;

    typedef struct packed {
        logic       rst;
        logic       lv;
        logic [3:0] data;
        logic       exp_ready;
        logic       exp_out;
        logic       exp_valid;
        logic       exp_last;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready), .load_data(ld),
        .ser_out(sout), .ser_valid(svalid), .ser_last(slast), .busy(sbusy)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(ready_m), .load_data(ld_m),
        .ser_out(sout_m), .ser_valid(svalid_m), .ser_last(slast_m), .busy(sbusy_m)
    );

    piso_serializer #(.WIDTH(1), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .load_valid(lv_1), .load_ready(ready_1), .load_data(ld_1),
        .ser_out(sout_1), .ser_valid(svalid_1), .ser_last(slast_1), .busy(sbusy_1)
    );

    // Downstream serial-in/parallel-out receiver, shifting in at the MSB end.
    always @(posedge clk) begin
        if (svalid) sipo <= {sout, sipo[3:1]};
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        lv   = 1'b0; ld   = '0;
        lv_m = 1'b0; ld_m = '0;
        lv_1 = 1'b0; ld_1 = '0;
        step();
        step();
        check("rst_ready", 4'(ready), 4'd0);
        check("rst_out", 4'(sout), 4'd0);
        check("rst_valid", 4'(svalid), 4'd0);
        check("rst_last", 4'(slast), 4'd0);
        check("rst_busy", 4'(sbusy), 4'd0);
        check("rst_msb_idle_level", 4'(sout_m), 4'd1);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 4'(ready), 4'd1);
        check("post_rst_ready_w1", 4'(ready_1), 4'd1);
    endtask

    // Scoreboard cycle: the model is the ordered list of bits still owed on the line.
    task automatic model_cycle(input logic v, input logic [3:0] d);
        logic       exp_ready;
        logic [0:0] b;
        lv = v;
        ld = d;
        #1;
        exp_ready = (exp_q.size() == 0);
        check("rand_ready", 4'(ready), 4'(exp_ready));
        if (v && exp_ready) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
            word_q.push_back(d);
        end
        step();
        if (prev_last) begin
            if (word_q.size() > 0) check("loopback_word", sipo, word_q.pop_front());
            else check("loopback_word_queue", 4'd0, 4'd1);
        end
        if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("rand_out", 4'(sout), 4'(b));
            check("rand_valid", 4'(svalid), 4'd1);
            check("rand_last", 4'(slast), 4'(exp_q.size() == 0));
            prev_last = (exp_q.size() == 0);
        end else begin
            check("rand_idle_valid", 4'(svalid), 4'd0);
            check("rand_idle_out", 4'(sout), 4'd0);
            check("rand_idle_last", 4'(slast), 4'd0);
            prev_last = 1'b0;
        end
    endtask

    initial begin
        // rst, lv, data, ready, out, valid, last
        vecs[0]  = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;
            lv  = vecs[i].lv;
            ld  = vecs[i].data;
            #1;
            check($sformatf("vec%0d_ready", i), 4'(ready), 4'(vecs[i].exp_ready));
            step();
            check($sformatf("vec%0d_out", i), 4'(sout), 4'(vecs[i].exp_out));
            check($sformatf("vec%0d_valid", i), 4'(svalid), 4'(vecs[i].exp_valid));
            check($sformatf("vec%0d_last", i), 4'(slast), 4'(vecs[i].exp_last));
            check($sformatf("vec%0d_busy", i), 4'(sbusy), 4'(vecs[i].exp_valid));
        end
        rst = 1'b0;
        lv  = 1'b0;

        // MSB-first build with idle level 1: 4'b1000 goes out as 1,0,0,0.
        lv_m = 1'b1;
        ld_m = 4'b1000;
        #1;
        check("msb_ready", 4'(ready_m), 4'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            lv_m = 1'b0;
            check($sformatf("msb_out%0d", i), 4'(sout_m), (i == 0) ? 4'd1 : 4'd0);
            check($sformatf("msb_valid%0d", i), 4'(svalid_m), 4'd1);
            check($sformatf("msb_last%0d", i), 4'(slast_m), (i == 3) ? 4'd1 : 4'd0);
        end
        step();
        check("msb_idle_out", 4'(sout_m), 4'd1);
        check("msb_idle_valid", 4'(svalid_m), 4'd0);

        // WIDTH=1 build: back-to-back single-bit frames.
        for (int i = 0; i < 3; i++) begin
            lv_1 = 1'b1;
            ld_1 = (i == 1) ? 1'b0 : 1'b1;
            #1;
            check($sformatf("w1_ready%0d", i), 4'(ready_1), 4'd1);
            step();
            check($sformatf("w1_out%0d", i), 4'(sout_1), (i == 1) ? 4'd0 : 4'd1);
            check($sformatf("w1_valid%0d", i), 4'(svalid_1), 4'd1);
            check($sformatf("w1_last%0d", i), 4'(slast_1), 4'd1);
        end
        lv_1 = 1'b0;
        step();
        check("w1_idle_valid", 4'(svalid_1), 4'd0);
        check("w1_idle_out", 4'(sout_1), 4'd0);

        // Random traffic with loopback into the receiver register.
        prev_last = 1'b0;
        for (int i = 0; i < 300; i++) begin
            model_cycle($urandom_range(0, 3) != 0, 4'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            model_cycle(1'b0, 4'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
